// File: rtl/pipe_pkg.sv
// Shared fetch-pipeline types: 30-bit word address, fetch FSM states,
// and the default reset / exception byte addresses.
package pipe_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

  typedef logic [29:0] waddr_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux for the fetch stage.
// Ports: active_i/in_fetch_i/ready_i fetch status; syscall_i, eret_i,
//   stall_i, redir_i events; rtgt_i redirect target; epc_i eret return;
//   exc_i exception vector; pc_i current PC; pend_* pending redirect;
//   pc_d_o next PC.  Macro BRANCH_DELAY_SLOT_EN selects delay-slot mode.
module pc_next_sel
  import pipe_pkg::*;
(
  input  logic   active_i,
  input  logic   in_fetch_i,
  input  logic   ready_i,
  input  logic   syscall_i,
  input  logic   eret_i,
  input  logic   stall_i,
  input  logic   redir_i,
  input  waddr_t rtgt_i,
  input  waddr_t epc_i,
  input  waddr_t exc_i,
  input  waddr_t pc_i,
  input  logic   pend_v_i,
  input  logic   pend_slot_i,
  input  waddr_t pend_tgt_i,
  output waddr_t pc_d_o
);

  waddr_t seq;
  assign seq = pc_i + 30'd1;

`ifdef BRANCH_DELAY_SLOT_EN
  logic unused_in_fetch;
  assign unused_in_fetch = in_fetch_i;
`else
  logic unused_slot;
  assign unused_slot = pend_slot_i;
`endif

  always_comb begin
    pc_d_o = pc_i;
    if (!active_i) begin
      pc_d_o = pc_i;
    end else if (syscall_i) begin
      pc_d_o = exc_i;
    end else if (eret_i) begin
      pc_d_o = epc_i;
    end else if (stall_i) begin
      pc_d_o = pc_i;
`ifdef BRANCH_DELAY_SLOT_EN
    end else if (ready_i) begin
      // Target is taken only once the delay slot fetch has completed.
      if (!redir_i && pend_v_i && !pend_slot_i)
        pc_d_o = pend_tgt_i;
      else
        pc_d_o = seq;
    end
`else
    end else if (redir_i && (in_fetch_i || ready_i)) begin
      pc_d_o = rtgt_i;
    end else if (ready_i && pend_v_i) begin
      pc_d_o = pend_tgt_i;
    end else if (ready_i) begin
      pc_d_o = seq;
    end
`endif
  end

endmodule

// File: rtl/if_pc_unit.sv
// Fetch-stage PC generator and imem request side of the IF/ID boundary.
// Ports: clk, rst (async high); Load_use, Jump, Branch, syscall, eret
//   events with Jump_target/Branch_target/EPC_in; imem_ready/imem_req/
//   imem_addr handshake; IF_PC, fetch_valid, EPC_out, squash to IF/ID.
//   Macro BRANCH_DELAY_SLOT_EN enables one delay slot on Jump/Branch.
module if_pc_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   Load_use,
  input  logic   Jump,
  input  logic   Branch,
  input  waddr_t Jump_target,
  input  waddr_t Branch_target,
  input  logic   syscall,
  input  logic   eret,
  input  waddr_t EPC_in,
  input  logic   imem_ready,
  output logic   imem_req,
  output waddr_t imem_addr,
  output waddr_t IF_PC,
  output logic   fetch_valid,
  output waddr_t EPC_out,
  output logic   squash
);

  localparam waddr_t RST_W = RESET_PC[31:2];
  localparam waddr_t EXC_W = EXC_VECTOR[31:2];

  fetch_state_t state_q, state_d;
  waddr_t pc_q, pc_d;
  waddr_t epc_q, epc_d;
  waddr_t pend_q, pend_d;
  logic   pend_v_q, pend_v_d;
  logic   slot_q, slot_d;

  logic   active, in_fetch, redir, evt;
  logic   discard;
  waddr_t rtgt;

  assign active   = state_q != IDLE;
  assign in_fetch = state_q == FETCH;
  assign redir    = Jump | Branch;
  assign rtgt     = Jump ? Jump_target : Branch_target;
  assign evt      = syscall | eret;

`ifdef BRANCH_DELAY_SLOT_EN
  assign discard = 1'b0;
`else
  // A pending target only exists in WAIT, so it always kills that fetch.
  assign discard = redir | pend_v_q;
`endif

  assign imem_req    = active & ~Load_use;
  assign imem_addr   = pc_q;
  assign IF_PC       = pc_q;
  assign EPC_out     = epc_q;
  assign fetch_valid = active & imem_ready & ~evt
                     & ~Load_use & ~discard;
  assign squash      = active & (evt | (~Load_use & discard
                     & (in_fetch | imem_ready)));

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    slot_d   = slot_q;
    epc_d    = epc_q;
    if (!active) begin
      state_d = FETCH;
    end else if (evt) begin
      state_d  = FETCH;
      pend_v_d = 1'b0;
      slot_d   = 1'b0;
      if (syscall) epc_d = pc_q + 30'd1;
    end else if (!Load_use) begin
      state_d = imem_ready ? FETCH : WAIT;
`ifdef BRANCH_DELAY_SLOT_EN
      if (redir) begin
        pend_v_d = 1'b1;
        pend_d   = rtgt;
        // Slot still owed when the current fetch has not returned.
        slot_d   = ~imem_ready;
      end else if (imem_ready && pend_v_q) begin
        if (slot_q) slot_d   = 1'b0;
        else        pend_v_d = 1'b0;
      end
`else
      if (redir && in_fetch) begin
        state_d = FETCH;
      end else if (redir && !imem_ready) begin
        pend_v_d = 1'b1;
        pend_d   = rtgt;
      end
      if (imem_ready) pend_v_d = 1'b0;
`endif
    end
  end

  pc_next_sel u_sel (
    .active_i    (active),
    .in_fetch_i  (in_fetch),
    .ready_i     (imem_ready),
    .syscall_i   (syscall),
    .eret_i      (eret),
    .stall_i     (Load_use),
    .redir_i     (redir),
    .rtgt_i      (rtgt),
    .epc_i       (EPC_in),
    .exc_i       (EXC_W),
    .pc_i        (pc_q),
    .pend_v_i    (pend_v_q),
    .pend_slot_i (slot_q),
    .pend_tgt_i  (pend_q),
    .pc_d_o      (pc_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RST_W;
      epc_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      slot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      slot_q   <= slot_d;
    end
  end

endmodule
